// File: rtl/cajero_pkg.sv
// Shared types and constants for the controlador_cajero ATM controller.
package cajero_pkg;

    localparam int         ANCHO_BALANCE  = 64;
    localparam logic       TRANS_DEPOSITO = 1'b0;
    localparam logic       TRANS_RETIRO   = 1'b1;
    localparam logic       TARJETA_PROPIA = 1'b1;
    localparam logic [1:0] MAX_INTENTOS   = 2'd3;

    typedef enum logic [2:0] {
        ESPERANDO_TARJETA = 3'd0,
        ESPERANDO_PIN     = 3'd1,
        VALIDANDO         = 3'd2,
        ESPERANDO_TRANS   = 3'd3,
        PROCESANDO        = 3'd4,
        FIN               = 3'd5,
        BLOQUEADO         = 3'd6
    } estado_t;

    // Deposits clamp at the all-ones balance instead of wrapping.
    function automatic logic [ANCHO_BALANCE-1:0] sumar_saturado(
        input logic [ANCHO_BALANCE-1:0] a,
        input logic [31:0]              b
    );
        logic [ANCHO_BALANCE:0] suma;
        suma = {1'b0, a} + {{(ANCHO_BALANCE-31){1'b0}}, b};
        return suma[ANCHO_BALANCE] ? '1 : suma[ANCHO_BALANCE-1:0];
    endfunction

endpackage

// File: rtl/detector_flanco.sv
// Rising-edge detector: flanco is high while senal is 1 and was 0 at the previous clock edge.
module detector_flanco (
    input  logic clk,
    input  logic reset,
    input  logic senal,
    output logic flanco
);

    logic previa;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) previa <= 1'b0;
        else        previa <= senal;
    end

    assign flanco = senal & ~previa;

endmodule

// File: rtl/controlador_cajero.sv
// ATM controller: card, 4-digit PIN with lockout after three failures, one deposit or withdrawal per session.
// Defining CONTROLADOR_CAJERO_COMISION_EN adds a fee to foreign-card withdrawals.
module controlador_cajero
    import cajero_pkg::*;
#(
    parameter logic [ANCHO_BALANCE-1:0] BALANCE_INICIAL = 64'd1000,
    parameter logic [31:0]              MONTO_COMISION  = 32'd5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        TARJETA_RECIBIDA,
    input  logic        TIPO_DE_TARJETA,
    input  logic [15:0] PIN,
    input  logic [3:0]  DIGITO,
    input  logic        DIGITO_STB,
    input  logic        TIPO_TRANS,
    input  logic [31:0] MONTO,
    input  logic        MONTO_STB,
    output logic        PIN_INCORRECTO,
    output logic        ADVERTENCIA,
    output logic        BLOQUEO,
    output logic        BALANCE_ACTUALIZADO,
    output logic        ENTREGAR_DINERO,
    output logic        FONDOS_INSUFICIENTES,
    output logic        COMISION,
    output logic [2:0]  estado
);

    estado_t                  est, est_sig;
    logic                     tipo_tarjeta, tipo_tarjeta_sig;
    logic [2:0]               cnt_dig, cnt_dig_sig;
    logic [15:0]              buffer, buffer_sig;
    logic [1:0]               intentos, intentos_sig, intentos_mas;
    logic [31:0]              monto_reg, monto_sig;
    logic                     tipo_trans_reg, tipo_trans_sig;
    logic [ANCHO_BALANCE-1:0] balance, balance_sig, costo;
    logic                     pin_inc_sig, adv_sig, bloq_sig;
    logic                     act_sig, entregar_sig, fondos_sig, comision_sig;
    logic                     flanco_digito, flanco_monto;
    logic                     aplica_comision;

    detector_flanco u_flanco_digito (
        .clk    (clk),
        .reset  (reset),
        .senal  (DIGITO_STB),
        .flanco (flanco_digito)
    );

    detector_flanco u_flanco_monto (
        .clk    (clk),
        .reset  (reset),
        .senal  (MONTO_STB),
        .flanco (flanco_monto)
    );

`ifdef CONTROLADOR_CAJERO_COMISION_EN
    assign aplica_comision = (tipo_tarjeta != TARJETA_PROPIA);
`else
    assign aplica_comision = 1'b0;
    logic unused_tarjeta;
    assign unused_tarjeta = tipo_tarjeta ^ TARJETA_PROPIA;
`endif

    assign costo = {{(ANCHO_BALANCE-32){1'b0}}, monto_reg}
                 + (aplica_comision ? {{(ANCHO_BALANCE-32){1'b0}}, MONTO_COMISION} : '0);
    assign intentos_mas = intentos + 2'd1;
    assign estado = est;

    always_comb begin
        est_sig          = est;
        tipo_tarjeta_sig = tipo_tarjeta;
        cnt_dig_sig      = cnt_dig;
        buffer_sig       = buffer;
        intentos_sig     = intentos;
        monto_sig        = monto_reg;
        tipo_trans_sig   = tipo_trans_reg;
        balance_sig      = balance;
        adv_sig          = ADVERTENCIA;
        bloq_sig         = BLOQUEO;
        pin_inc_sig      = 1'b0;
        act_sig          = 1'b0;
        entregar_sig     = 1'b0;
        fondos_sig       = 1'b0;
        comision_sig     = 1'b0;

        unique case (est)
            ESPERANDO_TARJETA: begin
                if (TARJETA_RECIBIDA) begin
                    tipo_tarjeta_sig = TIPO_DE_TARJETA;
                    cnt_dig_sig      = 3'd0;
                    est_sig          = ESPERANDO_PIN;
                end
            end
            ESPERANDO_PIN: begin
                if (!TARJETA_RECIBIDA) begin
                    est_sig = ESPERANDO_TARJETA;
                end else if (flanco_digito) begin
                    buffer_sig  = {buffer[11:0], DIGITO};
                    cnt_dig_sig = cnt_dig + 3'd1;
                    if (cnt_dig == 3'd3) est_sig = VALIDANDO;
                end
            end
            VALIDANDO: begin
                if (!TARJETA_RECIBIDA) begin
                    est_sig = ESPERANDO_TARJETA;
                end else if (buffer == PIN) begin
                    intentos_sig = 2'd0;
                    est_sig      = ESPERANDO_TRANS;
                end else begin
                    intentos_sig = intentos_mas;
                    pin_inc_sig  = 1'b1;
                    if (intentos_mas == 2'd2) adv_sig = 1'b1;
                    if (intentos_mas == MAX_INTENTOS) begin
                        bloq_sig = 1'b1;
                        est_sig  = BLOQUEADO;
                    end else begin
                        cnt_dig_sig = 3'd0;
                        est_sig     = ESPERANDO_PIN;
                    end
                end
            end
            ESPERANDO_TRANS: begin
                if (!TARJETA_RECIBIDA) begin
                    est_sig = ESPERANDO_TARJETA;
                end else if (flanco_monto) begin
                    monto_sig      = MONTO;
                    tipo_trans_sig = TIPO_TRANS;
                    est_sig        = PROCESANDO;
                end
            end
            PROCESANDO: begin
                unique case (tipo_trans_reg)
                    TRANS_DEPOSITO: begin
                        balance_sig = sumar_saturado(balance, monto_reg);
                        act_sig     = 1'b1;
                    end
                    TRANS_RETIRO: begin
                        if (costo > balance) begin
                            fondos_sig = 1'b1;
                        end else begin
                            balance_sig  = balance - costo;
                            act_sig      = 1'b1;
                            entregar_sig = 1'b1;
                            comision_sig = aplica_comision;
                        end
                    end
                endcase
                est_sig = FIN;
            end
            FIN: begin
                if (!TARJETA_RECIBIDA) begin
                    adv_sig      = 1'b0;
                    intentos_sig = 2'd0;
                    est_sig      = ESPERANDO_TARJETA;
                end
            end
            BLOQUEADO: begin
                est_sig = BLOQUEADO;
            end
            default: begin
                est_sig = ESPERANDO_TARJETA;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            est                  <= ESPERANDO_TARJETA;
            tipo_tarjeta         <= 1'b0;
            cnt_dig              <= 3'd0;
            buffer               <= 16'd0;
            intentos             <= 2'd0;
            monto_reg            <= 32'd0;
            tipo_trans_reg       <= 1'b0;
            balance              <= BALANCE_INICIAL;
            PIN_INCORRECTO       <= 1'b0;
            ADVERTENCIA          <= 1'b0;
            BLOQUEO              <= 1'b0;
            BALANCE_ACTUALIZADO  <= 1'b0;
            ENTREGAR_DINERO      <= 1'b0;
            FONDOS_INSUFICIENTES <= 1'b0;
            COMISION             <= 1'b0;
        end else begin
            est                  <= est_sig;
            tipo_tarjeta         <= tipo_tarjeta_sig;
            cnt_dig              <= cnt_dig_sig;
            buffer               <= buffer_sig;
            intentos             <= intentos_sig;
            monto_reg            <= monto_sig;
            tipo_trans_reg       <= tipo_trans_sig;
            balance              <= balance_sig;
            PIN_INCORRECTO       <= pin_inc_sig;
            ADVERTENCIA          <= adv_sig;
            BLOQUEO              <= bloq_sig;
            BALANCE_ACTUALIZADO  <= act_sig;
            ENTREGAR_DINERO      <= entregar_sig;
            FONDOS_INSUFICIENTES <= fondos_sig;
            COMISION             <= comision_sig;
        end
    end

endmodule

// File: tb/tb_controlador_cajero.sv
// Self-checking bench for controlador_cajero: directed scenarios plus randomized sessions,
// scored against a session-level model of the ATM rules.
`timescale 1ns/1ps
module tb_controlador_cajero;
    import cajero_pkg::*;

    localparam logic [15:0] PIN_OK  = 16'hE368;
    localparam logic [64:0] MAX_BAL = {1'b0, {64{1'b1}}};
`ifdef CONTROLADOR_CAJERO_COMISION_EN
    localparam int unsigned FEE = 5;
`else
    localparam int unsigned FEE = 0;
`endif

    logic        clk;
    logic        reset;
    logic        TARJETA_RECIBIDA;
    logic        TIPO_DE_TARJETA;
    logic [15:0] PIN;
    logic [3:0]  DIGITO;
    logic        DIGITO_STB;
    logic        TIPO_TRANS;
    logic [31:0] MONTO;
    logic        MONTO_STB;
    logic        PIN_INCORRECTO;
    logic        ADVERTENCIA;
    logic        BLOQUEO;
    logic        BALANCE_ACTUALIZADO;
    logic        ENTREGAR_DINERO;
    logic        FONDOS_INSUFICIENTES;
    logic        COMISION;
    logic [2:0]  estado;
    logic [6:0]  salidas;

    controlador_cajero dut (
        .clk                  (clk),
        .reset                (reset),
        .TARJETA_RECIBIDA     (TARJETA_RECIBIDA),
        .TIPO_DE_TARJETA      (TIPO_DE_TARJETA),
        .PIN                  (PIN),
        .DIGITO               (DIGITO),
        .DIGITO_STB           (DIGITO_STB),
        .TIPO_TRANS           (TIPO_TRANS),
        .MONTO                (MONTO),
        .MONTO_STB            (MONTO_STB),
        .PIN_INCORRECTO       (PIN_INCORRECTO),
        .ADVERTENCIA          (ADVERTENCIA),
        .BLOQUEO              (BLOQUEO),
        .BALANCE_ACTUALIZADO  (BALANCE_ACTUALIZADO),
        .ENTREGAR_DINERO      (ENTREGAR_DINERO),
        .FONDOS_INSUFICIENTES (FONDOS_INSUFICIENTES),
        .COMISION             (COMISION),
        .estado               (estado)
    );

    assign salidas = {PIN_INCORRECTO, ADVERTENCIA, BLOQUEO, BALANCE_ACTUALIZADO,
                      ENTREGAR_DINERO, FONDOS_INSUFICIENTES, COMISION};

    // Clock and cycle counter
    int unsigned ciclo = 0;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) ciclo <= ciclo + 1;

    // Scoreboard: {cycle the pulse must appear, expected salidas}
    logic [38:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // Session-level model
    logic [64:0] m_balance;
    int          m_intentos;
    bit          m_adv;
    bit          m_bloq;
    bit          m_propia;

    task automatic comparar(input string nombre, input logic [63:0] actual, input logic [63:0] esperado);
        checks++;
        if (actual !== esperado) begin
            errors++;
            $display("FAIL %s: actual=%0h esperado=%0h (t=%0t)", nombre, actual, esperado, $time);
        end
    endtask

    task automatic esperar_evento(input logic [6:0] vec);
        exp_q.push_back({32'(ciclo + 2), vec});
    endtask

    function automatic logic [15:0] pin_erroneo();
        logic [15:0] p;
        p = 16'($urandom);
        if (p == PIN_OK) p = ~p;
        return p;
    endfunction

    // Monitor: every cycle with a pulse consumes one expectation
    initial begin
        logic [38:0] e;
        forever begin
            @(negedge clk);
            if (reset && (PIN_INCORRECTO | BALANCE_ACTUALIZADO | ENTREGAR_DINERO |
                          FONDOS_INSUFICIENTES | COMISION)) begin
                if (exp_q.size() == 0) begin
                    comparar("evento_inesperado", 64'(salidas), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    comparar("ciclo_evento", 64'(ciclo), 64'(e[38:7]));
                    comparar("salidas_evento", 64'(salidas), 64'(e[6:0]));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout esperado=finish");
        $fatal(1, "bench timed out");
    end

    // Driver tasks
    task automatic reiniciar();
        reset            = 1'b0;
        TARJETA_RECIBIDA = 1'b0;
        TIPO_DE_TARJETA  = 1'b0;
        DIGITO           = 4'd0;
        DIGITO_STB       = 1'b0;
        TIPO_TRANS       = 1'b0;
        MONTO            = 32'd0;
        MONTO_STB        = 1'b0;
        repeat (3) @(negedge clk);
        comparar("salidas_reset", 64'(salidas), 64'd0);
        comparar("estado_reset", 64'(estado), 64'(ESPERANDO_TARJETA));
        m_balance  = 65'd1000;
        m_intentos = 0;
        m_adv      = 1'b0;
        m_bloq     = 1'b0;
        reset      = 1'b1;
        @(negedge clk);
    endtask

    task automatic insertar(input bit propia);
        @(negedge clk);
        TIPO_DE_TARJETA  = propia;
        TARJETA_RECIBIDA = 1'b1;
        m_propia         = propia;
        @(negedge clk);
    endtask

    task automatic retirar_tarjeta(input bit tras_transaccion);
        @(negedge clk);
        TARJETA_RECIBIDA = 1'b0;
        if (tras_transaccion && !m_bloq) begin
            m_adv      = 1'b0;
            m_intentos = 0;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic evaluar_pin(input bit correcto);
        if (correcto) begin
            m_intentos = 0;
        end else begin
            m_intentos++;
            if (m_intentos == 2) m_adv = 1'b1;
            if (m_intentos == 3) m_bloq = 1'b1;
            esperar_evento({1'b1, m_adv, m_bloq, 4'b0000});
        end
    endtask

    task automatic ingresar_digitos(input logic [15:0] pin_in, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            DIGITO     = pin_in[15-4*i -: 4];
            DIGITO_STB = 1'b1;
            MONTO_STB  = ($urandom_range(0, 3) == 0);
            if (i == 3 && !m_bloq) evaluar_pin(pin_in == PIN_OK);
            @(negedge clk);
            DIGITO_STB = 1'b0;
            MONTO_STB  = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic modelo_transaccion(input bit retiro, input logic [31:0] monto);
        logic [64:0] costo;
        if (!retiro) begin
            m_balance = m_balance + 65'(monto);
            if (m_balance > MAX_BAL) m_balance = MAX_BAL;
            esperar_evento({1'b0, m_adv, 1'b0, 4'b1000});
        end else begin
            costo = 65'(monto) + (m_propia ? 65'd0 : 65'(FEE));
            if (costo > m_balance) begin
                esperar_evento({1'b0, m_adv, 1'b0, 4'b0010});
            end else begin
                m_balance = m_balance - costo;
                esperar_evento({1'b0, m_adv, 1'b0, 3'b110, (!m_propia && FEE != 0)});
            end
        end
    endtask

    task automatic transaccion(input bit retiro, input logic [31:0] monto, input int sostener);
        @(negedge clk);
        TIPO_TRANS = retiro;
        MONTO      = monto;
        MONTO_STB  = 1'b1;
        DIGITO_STB = ($urandom_range(0, 3) == 0);
        if (!m_bloq) modelo_transaccion(retiro, monto);
        @(negedge clk);
        DIGITO_STB = 1'b0;
        MONTO      = $urandom;
        TIPO_TRANS = 1'($urandom);
        repeat (sostener - 1) @(negedge clk);
        MONTO_STB = 1'b0;
        @(negedge clk);
    endtask

    task automatic sesion(input bit propia, input bit retiro, input logic [31:0] monto);
        insertar(propia);
        ingresar_digitos(PIN_OK, 4);
        comparar("estado_pin_ok", 64'(estado), 64'(ESPERANDO_TRANS));
        transaccion(retiro, monto, 1);
        retirar_tarjeta(1'b1);
    endtask

    initial begin
        int          nw;
        int unsigned lim;
        PIN = PIN_OK;
        reiniciar();

        // Deposit on own card, then pin down the resulting balance from both sides
        sesion(1'b1, TRANS_DEPOSITO, 32'd15);
        sesion(1'b1, TRANS_RETIRO, 32'd1015);
        sesion(1'b1, TRANS_RETIRO, 32'd1);
        reiniciar();

        // Two wrong PINs raise ADVERTENCIA, a completed session clears it
        insertar(1'b1);
        ingresar_digitos(16'h1234, 4);
        comparar("advertencia_1", 64'(ADVERTENCIA), 64'(m_adv));
        ingresar_digitos(16'h1234, 4);
        comparar("advertencia_2", 64'(ADVERTENCIA), 64'(m_adv));
        ingresar_digitos(PIN_OK, 4);
        comparar("advertencia_pin_ok", 64'(ADVERTENCIA), 64'(m_adv));
        transaccion(TRANS_DEPOSITO, 32'd1, 1);
        retirar_tarjeta(1'b1);
        comparar("advertencia_fin", 64'(ADVERTENCIA), 64'(m_adv));

        // Lockout on third failure; everything ignored until reset
        insertar(1'b1);
        for (int k = 0; k < 3; k++) ingresar_digitos(16'h1234, 4);
        comparar("bloqueo", 64'(BLOQUEO), 64'(m_bloq));
        comparar("estado_bloqueado", 64'(estado), 64'(BLOQUEADO));
        retirar_tarjeta(1'b0);
        insertar(1'b1);
        ingresar_digitos(PIN_OK, 4);
        transaccion(TRANS_RETIRO, 32'd10, 2);
        comparar("bloqueo_persiste", 64'(BLOQUEO), 64'(m_bloq));
        comparar("estado_sigue_bloqueado", 64'(estado), 64'(BLOQUEADO));
        reiniciar();

        // Overdraw rejected, balance intact
        sesion(1'b1, TRANS_RETIRO, 32'd2000);
        sesion(1'b1, TRANS_RETIRO, 32'd1000);
        reiniciar();

        // Foreign-card withdrawal, then probe the remaining balance
        sesion(1'b0, TRANS_RETIRO, 32'd100);
        sesion(1'b1, TRANS_RETIRO, 32'(m_balance + 65'd1));
        sesion(1'b1, TRANS_RETIRO, 32'(m_balance));
        reiniciar();

        // Long amount strobe gives one transaction; aborts produce nothing and keep attempts
        insertar(1'b1);
        ingresar_digitos(PIN_OK, 4);
        transaccion(TRANS_DEPOSITO, 32'd50, 8);
        retirar_tarjeta(1'b1);
        insertar(1'b1);
        ingresar_digitos(PIN_OK, 2);
        retirar_tarjeta(1'b0);
        comparar("estado_abort", 64'(estado), 64'(ESPERANDO_TARJETA));
        insertar(1'b0);
        ingresar_digitos(16'h1111, 4);
        retirar_tarjeta(1'b0);
        insertar(1'b0);
        ingresar_digitos(16'h2222, 4);
        comparar("advertencia_tras_abort", 64'(ADVERTENCIA), 64'(m_adv));
        ingresar_digitos(PIN_OK, 4);
        transaccion(TRANS_RETIRO, 32'd40, 3);
        retirar_tarjeta(1'b1);

        // Randomized sessions
        for (int n = 0; n < 30; n++) begin
            insertar(1'($urandom_range(0, 1)));
            if ($urandom_range(0, 9) == 0) begin
                ingresar_digitos(16'($urandom), int'($urandom_range(1, 3)));
                retirar_tarjeta(1'b0);
            end else begin
                nw = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 3));
                for (int w = 0; w < nw && !m_bloq; w++) ingresar_digitos(pin_erroneo(), 4);
                if (m_bloq) begin
                    comparar("bloqueo_aleatorio", 64'(BLOQUEO), 64'd1);
                    retirar_tarjeta(1'b0);
                    reiniciar();
                end else begin
                    ingresar_digitos(PIN_OK, 4);
                    comparar("estado_pin_aleatorio", 64'(estado), 64'(ESPERANDO_TRANS));
                    if ($urandom_range(0, 1) == 1) begin
                        lim = 32'(m_balance) + 32'd20;
                        transaccion(TRANS_RETIRO, $urandom_range(1, lim), int'($urandom_range(1, 8)));
                    end else begin
                        transaccion(TRANS_DEPOSITO, $urandom_range(1, 5000), int'($urandom_range(1, 8)));
                    end
                    retirar_tarjeta(1'b1);
                end
            end
        end

        repeat (10) @(negedge clk);
        comparar("eventos_pendientes", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/controlador_cajero.md
# controlador_cajero

ATM transaction controller: the device side of the card/PIN/amount interface that the cajero testbench drives. It accepts a card and a 4-digit PIN entered one digit per strobe, and locks out after three wrong entries. It then executes one deposit or withdrawal against an internal balance register, with an optional commission for foreign cards. The bench instantiates it directly and checks its status outputs.

## Interface
- BALANCE_INICIAL, 64'd1000: balance loaded at reset.
- MONTO_COMISION, 32'd5: fee charged per foreign-card withdrawal (only with `COMISION_EN`).
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- TARJETA_RECIBIDA  in  1  level; card present.
- TIPO_DE_TARJETA  in  1  1 = own bank, 0 = foreign; sampled on card insertion.
- PIN  in  16  correct PIN, 4 BCD-free nibbles, MSB nibble = first digit.
- DIGITO  in  4  digit value, valid when DIGITO_STB rises.
- DIGITO_STB  in  1  digit strobe; rising edge is the event.
- TIPO_TRANS  in  1  0 = deposit, 1 = withdrawal; sampled with MONTO.
- MONTO  in  32  transaction amount, unsigned.
- MONTO_STB  in  1  amount strobe; rising edge is the event (may stay high many cycles).
- PIN_INCORRECTO  out  1  1-cycle pulse per wrong PIN.
- ADVERTENCIA  out  1  level, set on 2nd wrong PIN, cleared at session end.
- BLOQUEO  out  1  level, set on 3rd wrong PIN, cleared only by reset.
- BALANCE_ACTUALIZADO  out  1  1-cycle pulse when balance changes.
- ENTREGAR_DINERO  out  1  1-cycle pulse, same cycle as BALANCE_ACTUALIZADO on withdrawal.
- FONDOS_INSUFICIENTES  out  1  1-cycle pulse on rejected withdrawal.
- COMISION  out  1  1-cycle pulse when fee deducted.

## Operation
- States: ESPERANDO_TARJETA, ESPERANDO_PIN, VALIDANDO, ESPERANDO_TRANS, PROCESANDO, FIN, BLOQUEADO.
- ESPERANDO_TARJETA: on TARJETA_RECIBIDA=1 latch TIPO_DE_TARJETA, clear digit count -> ESPERANDO_PIN.
- ESPERANDO_PIN: each DIGITO_STB rising edge shifts DIGITO into 16-bit buffer (first digit ends in [15:12]); after 4th -> VALIDANDO.
- VALIDANDO: buffer == PIN -> ESPERANDO_TRANS, attempt count cleared. Else attempts+1, PIN_INCORRECTO pulse; attempts=2 sets ADVERTENCIA; attempts=3 sets BLOQUEO -> BLOQUEADO; otherwise back to ESPERANDO_PIN, count 0.
- ESPERANDO_TRANS: MONTO_STB rising edge latches MONTO, TIPO_TRANS -> PROCESANDO.
- PROCESANDO, deposit: balance += MONTO, saturating at 2^64-1; BALANCE_ACTUALIZADO.
- PROCESANDO, withdrawal: cost = MONTO (+MONTO_COMISION if foreign card and `COMISION_EN`), 64-bit arithmetic. cost > balance: FONDOS_INSUFICIENTES only, balance unchanged. Else balance -= cost; BALANCE_ACTUALIZADO, ENTREGAR_DINERO, plus COMISION if fee applied. Always -> FIN.
- FIN: wait TARJETA_RECIBIDA=0 -> ESPERANDO_TARJETA; clears ADVERTENCIA and attempt count.
- TARJETA_RECIBIDA=0 in ESPERANDO_PIN/VALIDANDO/ESPERANDO_TRANS: abort -> ESPERANDO_TARJETA, no pulses, attempt count kept (cleared only on correct PIN or reset).
- BLOQUEADO: absorbing; all strobes ignored until reset.
- Strobe edges outside their accepting state are ignored, not queued.

## Timing
- Reset (reset=0): state ESPERANDO_TARJETA, balance=BALANCE_INICIAL, all outputs 0, strobe history 0.
- Strobe edge detected by registering the strobe: event when strobe=1 and previous=0 at a clk edge.
- 4th digit edge at clock k: VALIDANDO during k+1; result outputs registered, visible k+2 for one cycle.
- MONTO_STB edge at clock k: PROCESANDO during k+1; result pulses visible k+2 for one cycle; state FIN at k+2.
- DIGITO_STB and MONTO_STB rising in the same cycle: only the one valid for the current state acts.
- All outputs registered; no combinational input-to-output paths.

## Configuration
- `CONTROLADOR_CAJERO_COMISION_EN` defined: foreign-card withdrawals cost MONTO+MONTO_COMISION and pulse COMISION.
- Undefined: no fee logic; COMISION tied 0; cost = MONTO for all cards.

## Structure
- Package cajero_pkg: state enum, TRANS_DEPOSITO=1'b0 / TRANS_RETIRO=1'b1, TARJETA_PROPIA=1'b1, MAX_INTENTOS=3, balance width 64.
- Sub-module detector_flanco (1-bit rising-edge detector, async active-low reset), instantiated for DIGITO_STB and MONTO_STB.

## Test plan
- Reset, card (own), digits E,3,6,8 with PIN=16'hE368, deposit MONTO=15 -> BALANCE_ACTUALIZADO pulse, balance 1015, no COMISION.
- Digits 1,2,3,4 twice then E,3,6,8 -> PIN_INCORRECTO twice, ADVERTENCIA high after 2nd, cleared after session end.
- Three wrong PINs -> BLOQUEO at 3rd, stays high; later card/strobes ignored until reset clears it.
- Correct PIN, withdrawal 2000 with balance 1000 -> FONDOS_INSUFICIENTES pulse, balance unchanged, no ENTREGAR_DINERO.
- Foreign card, withdrawal 100, macro defined -> ENTREGAR_DINERO+COMISION, balance 895; macro undefined -> balance 900, COMISION 0.
- MONTO_STB held high 8 cycles -> exactly one transaction; card removed mid-PIN -> ESPERANDO_TARJETA, no pulses.
